// File: rtl/wireframe_pkg.sv
// Shared types for the wireframe edge sequencer: FSM states, edge index, triangle record.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package wireframe_pkg;

  // Coordinate width of the line drawing core.
  localparam int WIREFRAME_WIDTH = 13;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CULL  = 2'd1,
    ST_ISSUE = 2'd2,
    ST_WAIT  = 2'd3
  } state_e;

  // Edge index 0..2: (v0,v1), (v1,v2), (v2,v0).
  typedef logic [1:0] edge_idx_t;

  // Triangle record at the default coordinate width. The sequencer declares
  // the same layout locally so it tracks its own WIDTH parameter.
  typedef struct packed {
    logic [WIREFRAME_WIDTH-1:0] x0;
    logic [WIREFRAME_WIDTH-1:0] y0;
    logic [WIREFRAME_WIDTH-1:0] x1;
    logic [WIREFRAME_WIDTH-1:0] y1;
    logic [WIREFRAME_WIDTH-1:0] x2;
    logic [WIREFRAME_WIDTH-1:0] y2;
  } tri_rec_t;

endpackage

// File: rtl/tri_fifo.sv
// Synchronous FIFO of triangle records; read data is valid whenever not empty.
// Latency: a push is visible on rd_dat (empty low) the cycle after the write edge.
// Backpressure: full blocks push; push while full and pop while empty are ignored.
// Ports: clk, reset (async, active-high), push/wr_dat, pop/rd_dat, full, empty.
module tri_fifo #(
  parameter type T     = logic,
  parameter int  DEPTH = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic push,
  input  T     wr_dat,
  input  logic pop,
  output T     rd_dat,
  output logic full,
  output logic empty
);

  localparam int AW = $clog2(DEPTH);

  // One extra pointer bit tells a wrapped (full) FIFO apart from an empty one.
  logic [AW:0] wr_ptr_q;
  logic [AW:0] rd_ptr_q;
  T            mem_q [DEPTH];

  assign empty  = (wr_ptr_q == rd_ptr_q);
  assign full   = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                  (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign rd_dat = mem_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push && !full)  wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop  && !empty) rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  // Storage needs no reset: entries are only read between push and pop.
  always_ff @(posedge clk) begin
    if (push && !full) mem_q[wr_ptr_q[AW-1:0]] <= wr_dat;
  end

endmodule

// File: rtl/wireframe_edge_sequencer.sv
// Splits queued triangles into three line commands (v0-v1, v1-v2, v2-v0) for the line core.
// Latency: first line_start two cycles after a push into an idle, empty block (three with culling).
// Backpressure: in_ready = FIFO not full (registered state only); next edge waits for line_finish.
// Ports: clk, reset (async, active-high); in_valid/in_ready/in_x0..in_y2 triangle input;
//        line_start, x0/y0/x1/y1 line command; line_finish from line core;
//        busy, tri_done, tri_culled status.
// Build option: WIREFRAME_BACKFACE_CULL_EN adds a CULL state that drops triangles with area <= 0.
module wireframe_edge_sequencer
  import wireframe_pkg::*;
#(
  parameter int WIDTH = WIREFRAME_WIDTH,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_x0,
  input  logic [WIDTH-1:0] in_y0,
  input  logic [WIDTH-1:0] in_x1,
  input  logic [WIDTH-1:0] in_y1,
  input  logic [WIDTH-1:0] in_x2,
  input  logic [WIDTH-1:0] in_y2,
  output logic             line_start,
  output logic [WIDTH-1:0] x0,
  output logic [WIDTH-1:0] y0,
  output logic [WIDTH-1:0] x1,
  output logic [WIDTH-1:0] y1,
  input  logic             line_finish,
  output logic             busy,
  output logic             tri_done,
  output logic             tri_culled
);

  typedef struct packed {
    logic [WIDTH-1:0] x0;
    logic [WIDTH-1:0] y0;
    logic [WIDTH-1:0] x1;
    logic [WIDTH-1:0] y1;
    logic [WIDTH-1:0] x2;
    logic [WIDTH-1:0] y2;
  } tri_t;

  tri_t in_tri, fifo_rd;
  logic fifo_full, fifo_empty, fifo_pop;

  state_e           state_q, state_d;
  edge_idx_t        edge_q, edge_d;
  tri_t             work_q, work_d;
  logic [WIDTH-1:0] x0_q, y0_q, x1_q, y1_q;
  logic [WIDTH-1:0] x0_d, y0_d, x1_d, y1_d;
  logic             line_start_q, line_start_d;
  logic             tri_done_q, tri_done_d;

  assign in_tri   = {in_x0, in_y0, in_x1, in_y1, in_x2, in_y2};
  assign in_ready = !fifo_full;

  tri_fifo #(.T(tri_t), .DEPTH(DEPTH)) u_fifo (
    .clk    (clk),
    .reset  (reset),
    .push   (in_valid && !fifo_full),
    .wr_dat (in_tri),
    .pop    (fifo_pop),
    .rd_dat (fifo_rd),
    .full   (fifo_full),
    .empty  (fifo_empty)
  );

`ifdef WIREFRAME_BACKFACE_CULL_EN
  // Twice the signed area; operands are zero-extended so the products never overflow.
  localparam int AREA_W = 2*WIDTH + 3;
  localparam int EXT_W  = AREA_W - WIDTH;
  logic signed [AREA_W-1:0] dx1, dy1, dx2, dy2, area;
  logic                     tri_culled_q, tri_culled_d;

  always_comb begin
    dx1  = $signed({{EXT_W{1'b0}}, work_q.x1}) - $signed({{EXT_W{1'b0}}, work_q.x0});
    dy1  = $signed({{EXT_W{1'b0}}, work_q.y1}) - $signed({{EXT_W{1'b0}}, work_q.y0});
    dx2  = $signed({{EXT_W{1'b0}}, work_q.x2}) - $signed({{EXT_W{1'b0}}, work_q.x0});
    dy2  = $signed({{EXT_W{1'b0}}, work_q.y2}) - $signed({{EXT_W{1'b0}}, work_q.y0});
    area = dx1 * dy2 - dx2 * dy1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) tri_culled_q <= 1'b0;
    else       tri_culled_q <= tri_culled_d;
  end
  assign tri_culled = tri_culled_q;
`else
  assign tri_culled = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    edge_d       = edge_q;
    work_d       = work_q;
    x0_d         = x0_q;
    y0_d         = y0_q;
    x1_d         = x1_q;
    y1_d         = y1_q;
    line_start_d = 1'b0;
    tri_done_d   = 1'b0;
    fifo_pop     = 1'b0;
`ifdef WIREFRAME_BACKFACE_CULL_EN
    tri_culled_d = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          work_d   = fifo_rd;
          edge_d   = '0;
`ifdef WIREFRAME_BACKFACE_CULL_EN
          state_d  = ST_CULL;
`else
          state_d  = ST_ISSUE;
`endif
        end
      end
`ifdef WIREFRAME_BACKFACE_CULL_EN
      ST_CULL: begin
        // Clockwise or degenerate (area <= 0) triangles produce no lines.
        if (area[AREA_W-1] || (area == '0)) begin
          tri_culled_d = 1'b1;
          state_d      = ST_IDLE;
        end else begin
          state_d      = ST_ISSUE;
        end
      end
`endif
      ST_ISSUE: begin
        line_start_d = 1'b1;
        state_d      = ST_WAIT;
        case (edge_q)
          2'd0: begin
            x0_d = work_q.x0; y0_d = work_q.y0; x1_d = work_q.x1; y1_d = work_q.y1;
          end
          2'd1: begin
            x0_d = work_q.x1; y0_d = work_q.y1; x1_d = work_q.x2; y1_d = work_q.y2;
          end
          default: begin
            x0_d = work_q.x2; y0_d = work_q.y2; x1_d = work_q.x0; y1_d = work_q.y0;
          end
        endcase
      end
      ST_WAIT: begin
        if (line_finish) begin
          if (edge_q == 2'd2) begin
            tri_done_d = 1'b1;
            state_d    = ST_IDLE;
          end else begin
            edge_d  = edge_q + 2'd1;
            state_d = ST_ISSUE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      edge_q       <= '0;
      work_q       <= '0;
      x0_q         <= '0;
      y0_q         <= '0;
      x1_q         <= '0;
      y1_q         <= '0;
      line_start_q <= 1'b0;
      tri_done_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      edge_q       <= edge_d;
      work_q       <= work_d;
      x0_q         <= x0_d;
      y0_q         <= y0_d;
      x1_q         <= x1_d;
      y1_q         <= y1_d;
      line_start_q <= line_start_d;
      tri_done_q   <= tri_done_d;
    end
  end

  assign line_start = line_start_q;
  assign tri_done   = tri_done_q;
  assign x0         = x0_q;
  assign y0         = y0_q;
  assign x1         = x1_q;
  assign y1         = y1_q;
  assign busy       = (state_q != ST_IDLE);

endmodule
